muldiv_unit: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the RV32M operations that the single-cycle ALU does not execute. This includes MULH, which is deliberately absent from the ALU.
- Sits beside the ALU in the execute stage. The core issues an operation over a valid/ready request channel, stalls, and takes the 32-bit result over a valid/ready response channel.
- One operation is in flight at a time. Latency is fixed for every operation.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one operation in flight, fixed 32-cycle latency,
// valid/ready request and response channels.
module muldiv_unit #(
  parameter int unsigned Bit_Width = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [Bit_Width-1:0] A,
  input  logic [Bit_Width-1:0] B,
  input  logic [2:0]           md_sel,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [Bit_Width-1:0] md_result,
  output logic                 busy
);

  localparam int unsigned W = Bit_Width;

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpMulhu  = 3'd3;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpDivu   = 3'd5;
  localparam logic [2:0] OpRem    = 3'd6;
  localparam logic [2:0] OpRemu   = 3'd7;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic [2:0]     op_q;
  logic [W-1:0]   hi_q, lo_q, opnd_q, result_q;
  logic [4:0]     cnt_q;
  logic           neg_res_q, neg_rem_q, div_zero_q, ovf_q;

  // Capture-side operand conditioning
  logic           a_signed, b_signed, neg_a, neg_b;
  logic [W-1:0]   a_mag, b_mag;

  // Iteration datapath
  logic [W:0]     mul_sum;
  logic [W:0]     div_shift;
  logic           div_fits;
  logic [W-1:0]   step_hi, step_lo;
  logic [2*W-1:0] prod, prod_s;
  logic [W-1:0]   quot, rem, final_res;

  always_comb begin
    a_signed = (md_sel == OpMul) || (md_sel == OpMulh) || (md_sel == OpMulhsu) ||
               (md_sel == OpDiv) || (md_sel == OpRem);
    b_signed = (md_sel == OpMul) || (md_sel == OpMulh) || (md_sel == OpDiv) ||
               (md_sel == OpRem);
    neg_a    = a_signed & A[W-1];
    neg_b    = b_signed & B[W-1];
    a_mag    = neg_a ? -A : A;
    b_mag    = neg_b ? -B : B;
  end

  // hi/lo hold {accumulator, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
    div_shift = {hi_q, lo_q[W-1]};
    div_fits  = div_shift >= {1'b0, opnd_q};
    if (op_q[2]) begin
      step_hi = div_fits ? (div_shift[W-1:0] - opnd_q) : div_shift[W-1:0];
      step_lo = {lo_q[W-2:0], div_fits};
    end else begin
      step_hi = mul_sum[W:1];
      step_lo = {mul_sum[0], lo_q[W-1:1]};
    end
  end

  always_comb begin
    prod   = {step_hi, step_lo};
    prod_s = neg_res_q ? -prod : prod;
    quot   = neg_res_q ? -step_lo : step_lo;
    // With a zero divisor every step fits, so the remainder naturally equals A
    rem    = neg_rem_q ? -step_hi : step_hi;
    unique case (op_q)
      OpMul:                      final_res = prod_s[W-1:0];
      OpMulh, OpMulhsu, OpMulhu:  final_res = prod_s[2*W-1:W];
      OpDiv, OpDivu: begin
        if (div_zero_q)  final_res = {W{1'b1}};
        else if (ovf_q)  final_res = {1'b1, {(W-1){1'b0}}};
        else             final_res = quot;
      end
      default: begin
        if (ovf_q) final_res = '0;
        else       final_res = rem;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (req_valid)       state_d = StCalc;
      StCalc: if (cnt_q == 5'd31)  state_d = StDone;
      StDone: if (resp_ready)      state_d = StIdle;
      default:                     state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      opnd_q     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q       <= md_sel;
            hi_q       <= '0;
            lo_q       <= md_sel[2] ? a_mag : b_mag;
            opnd_q     <= md_sel[2] ? b_mag : a_mag;
            cnt_q      <= '0;
            neg_res_q  <= neg_a ^ neg_b;
            neg_rem_q  <= neg_a;
            div_zero_q <= (B == '0);
            ovf_q      <= ((md_sel == OpDiv) || (md_sel == OpRem)) &&
                          (A == {1'b1, {(W-1){1'b0}}}) && (B == {W{1'b1}});
          end
        end
        StCalc: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign resp_valid = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign md_result  = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: RV32M results, latency, backpressure, reset abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] A, B;
  logic [2:0]  md_sel;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] md_result;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  muldiv_unit #(.Bit_Width(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .A          (A),
    .B          (B),
    .md_sel     (md_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .md_result  (md_result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Issue one request, scramble the inputs after capture, measure latency and check the result.
  task automatic run_op(input string tag, input logic [2:0] sel, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; md_sel = sel; A = a; B = b;
    @(posedge clk); #1;
    req_valid = 1'b0; A = $urandom; B = $urandom; md_sel = 3'($urandom);
    lat = 0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd32);
    check(tag, md_result, exp);
    @(posedge clk); #1;
    check({tag, "_rdy"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b1; A = '0; B = '0; md_sel = '0;
    #1;
    check("rst_req_ready",  {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_busy",       {31'd0, busy},       32'd0);
    check("rst_result",     md_result,           32'd0);
    #13 rst = 1'b0;

    run_op("mul_7_m3",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
    run_op("mulh_7_m3",   3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF);
    run_op("mulhu_max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulhsu_m1",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("div_m7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD);
    run_op("rem_m7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF);
    run_op("divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14);
    run_op("remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2);
    run_op("div_by0",     3'd4, 32'd123,      32'd0,        32'hFFFFFFFF);
    run_op("divu_by0",    3'd5, 32'd123,      32'd0,        32'hFFFFFFFF);
    run_op("rem_by0",     3'd6, 32'd123,      32'd0,        32'd123);
    run_op("remu_by0",    3'd7, 32'd123,      32'd0,        32'd123);
    run_op("rem_m5_by0",  3'd6, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB);
    run_op("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run_op("rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);

    // Backpressure: MUL 3*4 held in DONE for 10 cycles while a new request is offered
    resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; md_sel = 3'd0; A = 32'd3; B = 32'd4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk); #1;
    end
    check("bp_valid0", {31'd0, resp_valid}, 32'd1);
    check("bp_result0", md_result, 32'd12);
    req_valid = 1'b1; md_sel = 3'd0; A = 32'd9; B = 32'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_result", md_result, 32'd12);
      check("bp_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_rdy",   {31'd0, req_ready},  32'd1);
    check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
    check("bp_release_busy",  {31'd0, busy},       32'd0);

    // Reset in the middle of CALC aborts the operation
    @(negedge clk);
    req_valid = 1'b1; md_sel = 3'd0; A = 32'd11; B = 32'd13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
    end
    check("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("abort_req_ready",  {31'd0, req_ready},  32'd1);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("abort_busy",       {31'd0, busy},       32'd0);
    check("abort_result",     md_result,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (resp_valid) seen = 1'b1;
      end
      check("abort_no_resp", {31'd0, seen}, 32'd0);
    end

    run_op("mul_5_6", 3'd0, 32'd5, 32'd6, 32'd30);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
